// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: parallel<->bit-serial bridge for the bit-serial adder core.
// Define SERIAL_ADD_OVERFLOW_EN to add the signed-overflow output result_ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_cin,
    output logic             ser_first,
    input  logic             ser_sum,
    input  logic             ser_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_cout
`ifdef SERIAL_ADD_OVERFLOW_EN
    ,
    output logic             result_ovf
`endif
);
    localparam int CW = $clog2(WIDTH + LAT);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [CW-1:0]    cnt;
    logic             last;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic             msb_a, msb_b;
`endif
    // Zero-filled shifting empties the registers by cnt=WIDTH, giving idle drive for free.
    assign ser_a    = sh_a[0];
    assign ser_b    = sh_b[0];
    assign in_ready = state == IDLE;
    assign last     = cnt == CW'(WIDTH - 1 + LAT);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sh_a        <= '0;
            sh_b        <= '0;
            cnt         <= '0;
            ser_cin     <= 1'b0;
            ser_first   <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            result_cout <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
            msb_a       <= 1'b0;
            msb_b       <= 1'b0;
            result_ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sh_a      <= op_a;
                    sh_b      <= op_b;
                    ser_cin   <= op_cin;
                    ser_first <= 1'b1;
                    cnt       <= '0;
                    state     <= RUN;
`ifdef SERIAL_ADD_OVERFLOW_EN
                    msb_a     <= op_a[WIDTH-1];
                    msb_b     <= op_b[WIDTH-1];
`endif
                end
                RUN: begin
                    sh_a      <= sh_a >> 1;
                    sh_b      <= sh_b >> 1;
                    ser_cin   <= 1'b0;
                    ser_first <= 1'b0;
                    cnt       <= cnt + CW'(1);
                    if (cnt >= CW'(LAT))
                        result <= {ser_sum, result[WIDTH-1:1]};
                    if (last) begin
                        result_cout <= ser_cout;
                        out_valid   <= 1'b1;
                        state       <= DONE;
`ifdef SERIAL_ADD_OVERFLOW_EN
                        // the final captured bit lands in result's MSB this same edge
                        result_ovf  <= (msb_a == msb_b) & (ser_sum != msb_a);
`endif
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: closes the loop with a behavioural serial full adder and
// checks results against plain integer addition.
module tb_serial_add_ctrl;
    localparam int W = 8;
    localparam int L = 1;
    logic clk, rst, in_valid, in_ready, op_cin;
    logic [W-1:0] op_a, op_b, result;
    logic ser_a, ser_b, ser_cin, ser_first, ser_sum, ser_cout;
    logic out_valid, out_ready, result_cout;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic result_ovf;
`endif
    int checks = 0;
    int failures = 0;
    logic log_a[0:63], log_b[0:63], log_cin[0:63], log_first[0:63];
    logic carry, cm;

    serial_add_ctrl #(.WIDTH(W), .LAT(L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .ser_a(ser_a), .ser_b(ser_b), .ser_cin(ser_cin), .ser_first(ser_first),
        .ser_sum(ser_sum), .ser_cout(ser_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_cout(result_cout)
`ifdef SERIAL_ADD_OVERFLOW_EN
        , .result_ovf(result_ovf)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Serial adder core with one cycle of latency
    assign cm = ser_first ? ser_cin : carry;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_sum  <= 0;
            ser_cout <= 0;
            carry    <= 0;
        end else begin
            ser_sum  <= ser_a ^ ser_b ^ cm;
            ser_cout <= (ser_a & ser_b) | (cm & (ser_a ^ ser_b));
            carry    <= (ser_a & ser_b) | (cm & (ser_a ^ ser_b));
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        in_valid = 1; op_a = a; op_b = b; op_cin = c;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        @(negedge clk);
        log_a[0] = ser_a; log_b[0] = ser_b; log_cin[0] = ser_cin; log_first[0] = ser_first;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            log_a[k] = ser_a; log_b[k] = ser_b; log_cin[k] = ser_cin; log_first[k] = ser_first;
        end
    endtask

    task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        checks++;
        if (result !== s[W-1:0] || result_cout !== s[W]) begin
            failures++;
            $display("FAIL sum %h+%h+%0d: got %h/%0d want %h/%0d", a, b, c, result, result_cout, s[W-1:0], s[W]);
        end
`ifdef SERIAL_ADD_OVERFLOW_EN
        checks++;
        if (result_ovf !== ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]))) begin
            failures++;
            $display("FAIL ovf %h+%h+%0d: got %0d", a, b, c, result_ovf);
        end
`endif
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int k;
        start_op(a, b, c);
        wait_done(k);
        checks++;
        if (k !== W + L) begin
            failures++;
            $display("FAIL latency: got %0d want %0d", k, W + L);
        end
        check_result(a, b, c);
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (out_valid !== 0 || in_ready !== 1) begin
            failures++;
            $display("FAIL release: out_valid=%0d in_ready=%0d want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; out_ready = 0; op_a = 0; op_b = 0; op_cin = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ser_a, ser_b, ser_cin, ser_first, out_valid, result_cout} !== 6'b0 || result !== 0) begin
            failures++;
            $display("FAIL reset_outputs: got %b %h want 0", {ser_a, ser_b, ser_cin, ser_first, out_valid, result_cout}, result);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1) begin
            failures++;
            $display("FAIL reset_in_ready: got %0d want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        run_op(8'h5A, 8'h33, 0);
        run_op(8'hFF, 8'h01, 0);
        run_op(8'h7F, 8'h00, 1);
    endtask

    task automatic test_frame();
        logic [W-1:0] a;
        logic ok_a, ok_b, ok_first, ok_cin, ok_tail;
        a = 8'h81;
        run_op(a, 8'h00, 1);
        ok_a = 1; ok_b = 1; ok_first = 1; ok_cin = 1;
        for (int i = 0; i < W; i++) begin
            if (log_a[i] !== a[i]) ok_a = 0;
            if (log_b[i] !== 0) ok_b = 0;
            if (log_first[i] !== (i == 0)) ok_first = 0;
            if (log_cin[i] !== (i == 0)) ok_cin = 0;
        end
        ok_tail = {log_a[W], log_b[W], log_cin[W], log_first[W]} === 4'b0;
        checks++;
        if (!ok_a) begin failures++; $display("FAIL frame_ser_a: got %b%b%b%b%b%b%b%b want 10000001", log_a[0], log_a[1], log_a[2], log_a[3], log_a[4], log_a[5], log_a[6], log_a[7]); end
        checks++;
        if (!ok_b) begin failures++; $display("FAIL frame_ser_b: got nonzero want all 0"); end
        checks++;
        if (!ok_first) begin failures++; $display("FAIL frame_ser_first: got wrong pulse want only bit 0"); end
        checks++;
        if (!ok_cin) begin failures++; $display("FAIL frame_ser_cin: got wrong pulse want only bit 0"); end
        checks++;
        if (!ok_tail) begin failures++; $display("FAIL frame_tail: got %b%b%b%b want 0000", log_a[W], log_b[W], log_cin[W], log_first[W]); end
    endtask

    task automatic test_random();
        repeat (16) run_op(W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, r;
        logic c, rc, ok;
        int k;
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
        start_op(a, b, c);
        wait_done(k);
        check_result(a, b, c);
        r = result; rc = result_cout; ok = 1;
        repeat (5) begin
            in_valid = 1; op_a = W'($urandom); op_b = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1 || result !== r || result_cout !== rc || in_ready !== 0) ok = 0;
        end
        in_valid = 0;
        checks++;
        if (!ok) begin failures++; $display("FAIL backpressure_hold: got out_valid=%0d result=%h in_ready=%0d want 1/%h/0", out_valid, result, in_ready, r); end
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (out_valid !== 0 || in_ready !== 1) begin failures++; $display("FAIL backpressure_release: got %0d/%0d want 0/1", out_valid, in_ready); end
        ok = 1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 0 || in_ready !== 1) ok = 0;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL backpressure_no_accept: got out_valid=%0d in_ready=%0d want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_run();
        logic ok;
        start_op(8'hC3, 8'h5E, 1);
        repeat (4) @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({ser_a, ser_b, ser_cin, ser_first, out_valid, result_cout} !== 6'b0 || result !== 0 || in_ready !== 1) begin
            failures++;
            $display("FAIL abort_outputs: got %b %h in_ready=%0d want 0 0 1", {ser_a, ser_b, ser_cin, ser_first, out_valid, result_cout}, result, in_ready);
        end
        @(negedge clk);
        rst = 0;
        ok = 1;
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 0 || in_ready !== 1) ok = 0;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL abort_no_valid: got out_valid=%0d in_ready=%0d want 0/1", out_valid, in_ready); end
        run_op(8'h10, 8'h20, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_frame();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial operand transmitter and result receiver for the team's bit-serial adder datapath. It accepts two parallel WIDTH-bit operands and a carry-in over a valid/ready handshake, and shifts them out LSB-first on the serial operand lines. It collects the returning serial sum bits and final carry, and presents the reassembled parallel result on a second valid/ready handshake. It sits between parallel producer/consumer logic and the serial adder core.

## Interface
- WIDTH, 8: operand and result width in bits (≥2).
- LAT, 1: cycles from a serial bit being driven on ser_a/ser_b to its sum bit being valid on ser_sum (≥0).
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_cin  in  1  carry-in.
- ser_a  out  1  serial operand A bit, LSB first.
- ser_b  out  1  serial operand B bit, LSB first.
- ser_cin  out  1  carry-in; equals op_cin during bit 0, 0 otherwise.
- ser_first  out  1  high during bit 0 of a frame only.
- ser_sum  in  1  returning serial sum bit.
- ser_cout  in  1  returning carry-out; sampled with the last sum bit.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  assembled sum.
- result_cout  out  1  final carry-out.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. When in_valid & in_ready at an edge, load op_a/op_b into shift registers, latch op_cin, clear cnt, and go to RUN.
- RUN: cnt counts 0..WIDTH-1+LAT.
  - Drive phase, cnt<WIDTH: ser_a=A[cnt] and ser_b=B[cnt], sourced from shift register bit 0. ser_first and ser_cin are active only at cnt=0.
  - Idle drive, cnt≥WIDTH: ser_a, ser_b, ser_first and ser_cin are all 0.
  - Capture, cnt≥LAT: at each edge, result ← {ser_sum, result[WIDTH-1:1]}.
  - At cnt=WIDTH-1+LAT: sample ser_cout into result_cout, then go to DONE.
- DONE: out_valid=1. result and result_cout are held stable until out_valid & out_ready at an edge, then the block returns to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there, with no queuing.
- No same-cycle overlap: after the output handshake, the block is in IDLE for at least one cycle before the next accept.
- Arithmetic: the block does not add. result is exactly the captured bits, with first-captured bit = result[0].
- Reset, including mid-RUN or mid-DONE, aborts the operation with no out_valid for it. All registers and outputs go to their reset values.

## Timing
- Reset values:
  - Registers: state=IDLE, ser_a=ser_b=ser_cin=ser_first=0, out_valid=0, result=0, result_cout=0.
  - in_ready=1 once out of reset.
- Accept edge E0: bit 0 appears on the serial lines in the cycle immediately after E0.
- Bit i is driven in cycle E0+1+i. Its sum bit is sampled at the edge ending cycle cnt=i+LAT.
- out_valid rises at edge E0+WIDTH+LAT.
- Minimum period per operation: WIDTH+LAT+2 cycles, with out_ready held high.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Configuration
- SERIAL_ADD_OVERFLOW_EN defined: adds output port result_ovf (1 bit) and keeps copies of the operand MSBs.
  - result_ovf = (A[MSB]==B[MSB]) & (result[MSB]!=A[MSB]).
  - Valid with out_valid and held like result.
  - Reset value 0.
- Not defined: no result_ovf port and no MSB storage. All other behaviour is identical.

## Test plan
Bench: WIDTH=8, LAT=1, with a behavioural bit-serial full-adder model closing the loop. The model clears its carry on ser_first and loads ser_cin.
- 0x5A + 0x33, cin=0 -> result=0x8D, result_cout=0; out_valid rises 9 cycles after the accept edge.
- 0xFF + 0x01, cin=0 -> result=0x00, result_cout=1; result_ovf=0 when SERIAL_ADD_OVERFLOW_EN is defined.
- 0x7F + 0x00, cin=1 -> result=0x80, result_cout=0; result_ovf=1 when the macro is defined.
- Frame check with op_a=0x81, op_b=0x00:
  - ser_a sequence is 1,0,0,0,0,0,0,1.
  - ser_first is high exactly one cycle, the cycle after accept.
  - ser_cin equals op_cin only in that cycle.
  - All serial lines are 0 in the LAT trailing cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid.
  - result, result_cout and out_valid stay stable.
  - in_ready=0 throughout and no operation is accepted.
  - Raising out_ready returns the block to IDLE the next cycle.
- Reset at cnt=3 of RUN:
  - All outputs are at reset values immediately.
  - No out_valid appears for the aborted operation.
  - After release, in_ready=1, and a following 0x10 + 0x20 yields 0x30.
